spi_sequencer: RTL and testbench

Autonomous bus master that sits directly upstream of the SPI peripheral and drives its register port (write strobe, register select, data address, write data, read data). It accepts a burst of up to MAX_WORDS transmit words from a stream interface and loads them into the SPI data register. It then launches the transfer through the SPI control register, polls for completion, and streams the received words back out. This lets a hardware client run SPI transactions without CPU involvement.

---
 rtl/spi_pkg.sv | 49 ++++
 rtl/spi_seq_fsm.sv | 127 ++++++++++++
 rtl/spi_sequencer.sv | 104 ++++++++++
 tb/tb_spi_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sequencer: control-register field layout,
// register-select codes, sequencer state type and the control-word builder.
package spi_pkg;

  localparam int unsigned SEND_BIT    = 0;
  localparam int unsigned CS_CTRL_BIT = 1;
  localparam int unsigned ALL1_BIT    = 2;
  localparam int unsigned ALL0_BIT    = 3;
  localparam int unsigned N_TX_LSB    = 4;
  localparam int unsigned N_TX_MSB    = 12;
  localparam int unsigned N_RX_LSB    = 16;
  localparam int unsigned N_RX_MSB    = 25;

  localparam logic REG_SEL_CTRL = 1'b0;
  localparam logic REG_SEL_DATA = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_POLL_A,
    ST_POLL_S,
    ST_READ_A,
    ST_READ_S,
    ST_RX_OUT,
    ST_DONE
  } seq_state_e;

  // Assemble a control-register word from its individual fields.
  function automatic logic [31:0] build_ctrl(
    input logic       send,
    input logic       cs_ctrl,
    input logic       all1,
    input logic       all0,
    input logic [8:0] n_tx_end,
    input logic [9:0] n_rx
  );
    logic [31:0] w;
    w                     = '0;
    w[SEND_BIT]           = send;
    w[CS_CTRL_BIT]        = cs_ctrl;
    w[ALL1_BIT]           = all1;
    w[ALL0_BIT]           = all0;
    w[N_TX_MSB:N_TX_LSB]  = n_tx_end;
    w[N_RX_MSB:N_RX_LSB]  = n_rx;
    return w;
  endfunction

endpackage

// File: rtl/spi_seq_fsm.sv
// Sequencer control: state register, next-state logic, word index, poll
// counter and the sticky timeout flag. Exposes state decodes to the datapath.
module spi_seq_fsm
  import spi_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned POLL_MAX  = 1024,
  parameter int unsigned NW        = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [NW-1:0] i_n_words,
  input  logic          i_tx_valid,
  input  logic          i_rx_ready,
  input  logic          i_poll_busy,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_tx_ready,
  output logic          o_rx_valid,
  output logic          o_tx_hs,
  output logic          o_kick,
  output logic          o_read_a,
  output logic          o_read_s,
  output logic [9:0]    o_idx,
  output logic [9:0]    o_n
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  seq_state_e    r_state;
  seq_state_e    w_state_nxt;
  logic [9:0]    r_idx;
  logic [9:0]    r_n;
  logic [PW-1:0] r_poll;
  logic          r_err;

  logic [9:0]    w_n_clamp;
  logic          w_last;
  logic          w_tx_hs;
  logic          w_rx_hs;
  logic          w_poll_last;

  // Clamp the requested burst length to the buffer depth.
  always_comb begin
    w_n_clamp = 10'(i_n_words);
    if (32'(i_n_words) > MAX_WORDS) w_n_clamp = 10'(MAX_WORDS);
  end

  assign w_last      = (r_idx == (r_n - 10'd1));
  assign o_tx_ready  = (r_state == ST_LOAD) && (r_n != 10'd0);
  assign w_tx_hs     = o_tx_ready && i_tx_valid;
  assign w_rx_hs     = (r_state == ST_RX_OUT) && i_rx_ready;
  assign w_poll_last = (r_poll == PW'(POLL_MAX - 1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (r_n == 10'd0)          w_state_nxt = ST_DONE;
        else if (w_tx_hs && w_last) w_state_nxt = ST_KICK;
      end
      ST_KICK:   w_state_nxt = ST_POLL_A;
      ST_POLL_A: w_state_nxt = ST_POLL_S;
      ST_POLL_S: begin
        if (!i_poll_busy)     w_state_nxt = ST_READ_A;
        else if (w_poll_last) w_state_nxt = ST_DONE;
        else                  w_state_nxt = ST_POLL_A;
      end
      ST_READ_A: w_state_nxt = ST_READ_S;
      ST_READ_S: w_state_nxt = ST_RX_OUT;
      ST_RX_OUT: if (w_rx_hs) w_state_nxt = w_last ? ST_DONE : ST_READ_A;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst length, word index, poll counter and timeout flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_n    <= '0;
      r_poll <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_n   <= w_n_clamp;
            r_idx <= '0;
            r_err <= 1'b0;
          end
        end
        ST_LOAD:   if (w_tx_hs && !w_last) r_idx <= r_idx + 10'd1;
        ST_KICK:   r_poll <= '0;
        ST_POLL_S: begin
          if (!i_poll_busy)     r_idx  <= '0;
          else if (w_poll_last) r_err  <= 1'b1;
          else                  r_poll <= r_poll + PW'(1);
        end
        ST_RX_OUT: if (w_rx_hs && !w_last) r_idx <= r_idx + 10'd1;
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_err      = r_err;
  assign o_rx_valid = (r_state == ST_RX_OUT);
  assign o_tx_hs    = w_tx_hs;
  assign o_kick     = (r_state == ST_KICK);
  assign o_read_a   = (r_state == ST_READ_A);
  assign o_read_s   = (r_state == ST_READ_S);
  assign o_idx      = r_idx;
  assign o_n        = r_n;

endmodule

// File: rtl/spi_sequencer.sv
// SPI register-port bus master: loads a burst of transmit words, kicks the
// transfer, polls for completion and streams the received words back out.
module spi_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned POLL_MAX  = 1024,
  localparam int unsigned NW       = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk_pi,
  input  logic          reset_pi,
  input  logic          start_pi,
  input  logic [NW-1:0] n_words_pi,
  input  logic [31:0]   tx_word_pi,
  input  logic          tx_valid_pi,
  output logic          tx_ready_po,
  output logic [31:0]   rx_word_po,
  output logic          rx_valid_po,
  input  logic          rx_ready_pi,
  output logic          busy_po,
  output logic          done_po,
  output logic          err_po,
  output logic          spi_wr_po,
  output logic          spi_reg_sel_po,
  output logic [9:0]    spi_addr_po,
  output logic [31:0]   spi_wdata_po,
  input  logic [31:0]   spi_rdata_pi
);

  logic        w_tx_hs;
  logic        w_kick;
  logic        w_read_a;
  logic        w_read_s;
  logic [9:0]  w_idx;
  logic [9:0]  w_n;

  logic        r_spi_wr;
  logic        r_spi_reg_sel;
  logic [9:0]  r_spi_addr;
  logic [31:0] r_spi_wdata;
  logic [31:0] r_rx_word;

  spi_seq_fsm #(
    .MAX_WORDS (MAX_WORDS),
    .POLL_MAX  (POLL_MAX),
    .NW        (NW)
  ) u_fsm (
    .i_clk       (clk_pi),
    .i_rst_n     (reset_pi),
    .i_start     (start_pi),
    .i_n_words   (n_words_pi),
    .i_tx_valid  (tx_valid_pi),
    .i_rx_ready  (rx_ready_pi),
    .i_poll_busy (spi_rdata_pi[SEND_BIT]),
    .o_busy      (busy_po),
    .o_done      (done_po),
    .o_err       (err_po),
    .o_tx_ready  (tx_ready_po),
    .o_rx_valid  (rx_valid_po),
    .o_tx_hs     (w_tx_hs),
    .o_kick      (w_kick),
    .o_read_a    (w_read_a),
    .o_read_s    (w_read_s),
    .o_idx       (w_idx),
    .o_n         (w_n)
  );

  // Registered SPI port: each state's access appears on the bus the following
  // cycle, so a poll/read address is stable when the next state samples rdata.
  always_ff @(posedge clk_pi or negedge reset_pi) begin
    if (!reset_pi) begin
      r_spi_wr      <= 1'b0;
      r_spi_reg_sel <= REG_SEL_CTRL;
      r_spi_addr    <= '0;
      r_spi_wdata   <= '0;
      r_rx_word     <= '0;
    end else begin
      r_spi_wr      <= 1'b0;
      r_spi_reg_sel <= REG_SEL_CTRL;
      r_spi_addr    <= '0;
      r_spi_wdata   <= '0;
      if (w_tx_hs) begin
        r_spi_wr      <= 1'b1;
        r_spi_reg_sel <= REG_SEL_DATA;
        r_spi_addr    <= w_idx;
        r_spi_wdata   <= tx_word_pi;
      end else if (w_kick) begin
        r_spi_wr      <= 1'b1;
        r_spi_wdata   <= build_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 9'(w_n - 10'd1), 10'd0);
      end else if (w_read_a) begin
        r_spi_reg_sel <= REG_SEL_DATA;
        r_spi_addr    <= w_idx;
      end
      if (w_read_s) r_rx_word <= spi_rdata_pi;
    end
  end

  assign spi_wr_po      = r_spi_wr;
  assign spi_reg_sel_po = r_spi_reg_sel;
  assign spi_addr_po    = r_spi_addr;
  assign spi_wdata_po   = r_spi_wdata;
  assign rx_word_po     = r_rx_word;

endmodule

// File: tb/tb_spi_sequencer.sv
// Directed plus randomized bursts against a transaction-level reference model
// and a small behavioural SPI peripheral.
module tb_spi_sequencer;

  localparam int MW = 8;
  localparam int PM = 6;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] n_words = '0;
  logic [31:0]   tx_word = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [31:0]   rx_word;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          busy_o, done_o, err_o;
  logic          spi_wr, spi_sel;
  logic [9:0]    spi_addr;
  logic [31:0]   spi_wdata;
  logic [31:0]   spi_rdata;

  spi_sequencer #(.MAX_WORDS(MW), .POLL_MAX(PM)) dut (
    .clk_pi         (clk),
    .reset_pi       (rst_n),
    .start_pi       (start),
    .n_words_pi     (n_words),
    .tx_word_pi     (tx_word),
    .tx_valid_pi    (tx_valid),
    .tx_ready_po    (tx_ready),
    .rx_word_po     (rx_word),
    .rx_valid_po    (rx_valid),
    .rx_ready_pi    (rx_ready),
    .busy_po        (busy_o),
    .done_po        (done_o),
    .err_po         (err_o),
    .spi_wr_po      (spi_wr),
    .spi_reg_sel_po (spi_sel),
    .spi_addr_po    (spi_addr),
    .spi_wdata_po   (spi_wdata),
    .spi_rdata_pi   (spi_rdata)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: send stays set for busy_cfg polls (2 cycles each).
  logic [31:0] rxmem [0:1023];
  int busy_cfg = 0;
  int busy_cnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) busy_cnt <= 0;
    else if (spi_wr && !spi_sel && spi_wdata[0]) busy_cnt <= 2 * busy_cfg;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  assign spi_rdata = spi_sel ? rxmem[spi_addr] : {31'd0, busy_cnt != 0};

  // Stimulus config and observation logs.
  logic [31:0] tx_q[$];
  logic [31:0] exp_w[$];
  int tx_mode = 0, rx_mode = 0, stall_cfg = 0;
  bit junk = 0;
  int wr_addr_q[$], wr_cyc_q[$], rd_addr_q[$];
  logic [31:0] wr_data_q[$], ctrl_q[$], rx_obs_q[$];
  int ctrl_cyc, done_cnt, done_cyc, first_rxv, stab_err;

  // Drivers and monitor, all acting on the falling edge.
  initial begin
    bit tx_hs_p, rx_hs, rxv_prev;
    logic [31:0] rx_prev;
    int stall_ctr;
    tx_hs_p = 0; rxv_prev = 0; rx_prev = '0; stall_ctr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_hs_p = 0; rxv_prev = 0; stall_ctr = 0;
        tx_valid = 1'b0; rx_ready = 1'b0;
        continue;
      end
      if (tx_hs_p && tx_q.size() > 0) void'(tx_q.pop_front());
      if (spi_wr && spi_sel) begin
        wr_addr_q.push_back(int'(spi_addr)); wr_data_q.push_back(spi_wdata); wr_cyc_q.push_back(cyc);
      end
      if (spi_wr && !spi_sel) begin ctrl_q.push_back(spi_wdata); ctrl_cyc = cyc; end
      if (!spi_wr && spi_sel) rd_addr_q.push_back(int'(spi_addr));
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (rx_valid && first_rxv < 0) first_rxv = cyc;
      if (rxv_prev && rx_valid && rx_word !== rx_prev) stab_err++;
      if (tx_q.size() > 0) begin
        tx_valid = (tx_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        tx_word  = tx_q[0];
      end else begin
        tx_valid = junk;
        tx_word  = 32'hDEAD_BEEF;
      end
      tx_hs_p = tx_valid && tx_ready && (tx_q.size() > 0);
      if (rx_valid) begin
        case (rx_mode)
          0:       rx_ready = 1'b1;
          1:       rx_ready = (stall_ctr >= stall_cfg);
          default: rx_ready = ($urandom_range(0, 2) != 0);
        endcase
      end else rx_ready = 1'($urandom_range(0, 1));
      rx_hs = rx_valid && rx_ready;
      if (rx_hs) begin rx_obs_q.push_back(rx_word); stall_ctr = 0; end
      else if (rx_valid) stall_ctr++;
      rxv_prev = rx_valid && !rx_hs;
      rx_prev  = rx_word;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_busy"}, {31'd0, busy_o}, 0);
    chk({p, "_done"}, {31'd0, done_o}, 0);
    chk({p, "_err"}, {31'd0, err_o}, 0);
    chk({p, "_tx_ready"}, {31'd0, tx_ready}, 0);
    chk({p, "_rx_valid"}, {31'd0, rx_valid}, 0);
    chk({p, "_spi_wr"}, {31'd0, spi_wr}, 0);
    chk({p, "_reg_sel"}, {31'd0, spi_sel}, 0);
    chk({p, "_addr"}, {22'd0, spi_addr}, 0);
    chk({p, "_wdata"}, spi_wdata, 0);
    chk({p, "_rx_word"}, rx_word, 0);
  endtask

  // Run one burst and compare every observation with the reference model.
  task automatic run_burst(input int n_req, input int polls, input int txm, input int rxm,
                           input int stall, input bit jk, input bit directed);
    int n_eff, s0;
    bit exp_err;
    n_eff = (n_req > MW) ? MW : n_req;
    exp_w.delete(); tx_q.delete();
    for (int k = 0; k < n_eff; k++) begin
      exp_w.push_back(directed ? (32'hA5A5_0001 + 32'(k)) : $urandom);
      rxmem[k] = directed ? (32'h11 * 32'(k + 1)) : $urandom;
    end
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); ctrl_q.delete();
    rd_addr_q.delete(); rx_obs_q.delete();
    done_cnt = 0; done_cyc = -1; first_rxv = -1; stab_err = 0; ctrl_cyc = -1;
    busy_cfg = polls; tx_mode = txm; rx_mode = rxm; stall_cfg = stall; junk = jk;
    exp_err = (n_eff > 0) && (polls >= PM);
    foreach (exp_w[k]) tx_q.push_back(exp_w[k]);
    step();
    start = 1'b1; n_words = NW'(n_req); s0 = cyc;
    step();
    start = 1'b0; n_words = NW'($urandom);
    chk("busy_at_1", {31'd0, busy_o}, 1);
    chk("tx_ready_at_1", {31'd0, tx_ready}, (n_eff != 0) ? 1 : 0);
    chk("err_cleared", {31'd0, err_o}, 0);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      start = (n_eff > 0 && i == 3);
      step();
    end
    start = 1'b0;
    chk("done_seen", (done_cnt != 0) ? 1 : 0, 1);
    repeat (3) step();
    chk("done_count", done_cnt, 1);
    chk("busy_after", {31'd0, busy_o}, 0);
    chk("err", {31'd0, err_o}, {31'd0, exp_err});
    chk("wr_count", wr_addr_q.size(), n_eff);
    if (wr_addr_q.size() == n_eff) begin
      for (int k = 0; k < n_eff; k++) begin
        chk("wr_addr", wr_addr_q[k], k);
        chk("wr_data", wr_data_q[k], exp_w[k]);
        if (txm == 0) chk("wr_consecutive", wr_cyc_q[k] - wr_cyc_q[0], k);
      end
    end
    if (n_eff == 0) begin
      chk("ctrl_count_n0", ctrl_q.size(), 0);
      chk("done_lat_n0", done_cyc - s0, 2);
    end else begin
      chk("ctrl_count", ctrl_q.size(), 1);
      if (ctrl_q.size() == 1) chk("ctrl_word", ctrl_q[0], 32'h1 | (32'(n_eff - 1) << 4));
      if (wr_cyc_q.size() == n_eff) chk("ctrl_after_last", ctrl_cyc - wr_cyc_q[n_eff - 1], 1);
    end
    if (exp_err) begin
      chk("timeout_reads", rd_addr_q.size(), 0);
      chk("timeout_rx", rx_obs_q.size(), 0);
      chk("timeout_done_lat", done_cyc - ctrl_cyc, 2 * PM);
    end else if (n_eff > 0) begin
      chk("rd_count", rd_addr_q.size(), n_eff);
      chk("rx_count", rx_obs_q.size(), n_eff);
      for (int k = 0; k < n_eff; k++) begin
        if (k < rd_addr_q.size()) chk("rd_addr", rd_addr_q[k], k);
        if (k < rx_obs_q.size()) chk("rx_word", rx_obs_q[k], rxmem[k]);
      end
      chk("first_rx_lat", first_rxv - ctrl_cyc, 2 * polls + 4);
    end
    chk("rx_stable", stab_err, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rxmem[i] = '0;
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    run_burst(3, 5, 0, 0, 0, 1'b1, 1'b1);        // directed N=3, tx_valid held high
    run_burst(2, 2, 0, 1, 10, 1'b0, 1'b0);       // rx_ready stalled 10 cycles per word
    run_burst(2, 1000, 0, 0, 0, 1'b0, 1'b0);     // send stuck -> timeout
    run_burst(1, 0, 0, 0, 0, 1'b0, 1'b0);        // next start clears err, immediate completion
    run_burst(0, 0, 0, 0, 0, 1'b1, 1'b0);        // empty burst
    run_burst(MW + 3, 1, 0, 0, 0, 1'b0, 1'b0);   // clamped to MAX_WORDS
    run_burst(MW, PM - 1, 1, 2, 0, 1'b0, 1'b0);  // last poll before timeout succeeds
    for (int r = 0; r < 8; r++)
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, PM + 1)), 1, 2, 0,
                1'($urandom_range(0, 1)), 1'b0);

    // Asynchronous reset while a word is waiting in RX_OUT.
    tx_q.delete();
    foreach (exp_w[k]) exp_w[k] = 0;
    for (int k = 0; k < 3; k++) tx_q.push_back($urandom);
    busy_cfg = 1; tx_mode = 0; rx_mode = 1; stall_cfg = 1000; junk = 0;
    step();
    start = 1'b1; n_words = 4'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && !rx_valid; i++) step();
    chk("rst_reach_rx", {31'd0, rx_valid}, 1);
    step();
    #6 rst_n = 1'b0;
    #1 check_zero("async_rst");
    tx_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    run_burst(3, 2, 1, 2, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
